// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and defaults for the serial add/subtract engine
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} addsub_state_t;
  localparam int ADDSUB_WIDTH_DEFAULT = 32;
endpackage

// File: rtl/serial_addsub_ctrl_fa.sv
// FA: 1-bit full adder, the only arithmetic element of the serial engine
module FA (
  input  logic A_i,
  input  logic B_i,
  input  logic C_i,
  output logic S_o,
  output logic CA_o
);
  assign S_o  = A_i ^ B_i ^ C_i;
  assign CA_o = (A_i & B_i) | (C_i & (A_i ^ B_i));
endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: LSB-first bit-serial add/subtract with start/ready and done pulse
module serial_addsub_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH_DEFAULT,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);
  addsub_state_t state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, acc_q, acc_d, result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic ready_q, ready_d, done_q, done_d;
  logic fa_s, fa_co;
  FA u_fa (.A_i(sa_q[0]), .B_i(sb_q[0]), .C_i(carry_q), .S_o(fa_s), .CA_o(fa_co));
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: if (start_i) begin
        sa_d    = a_i;
        sb_d    = b_i ^ {WIDTH{sub_i}};
        carry_d = sub_i;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        acc_d   = {fa_s, acc_q[WIDTH-1:1]};
        carry_d = fa_co;
        // flags publish only on the last bit so no partial result leaks out
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d  = DONE;
          result_d = acc_d;
          cout_d   = fa_co;
          ovf_d    = fa_co ^ carry_q;
          zero_d   = acc_d == '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = state_d == IDLE;
    done_d  = state_d == DONE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end
  assign ready_o  = ready_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign cout_o   = cout_q;
  assign ovf_o    = ovf_q;
  assign zero_o   = zero_q;
endmodule
